// File: rtl/axis_pipe_pkg.sv
// axis_pipe_pkg: shared constants and types for the AXIS burst pipeline
package axis_pipe_pkg;
  localparam int DATA_WIDTH_DEF = 32;
  typedef enum logic {COLLECT, RELEASE} burst_state_t;
  function automatic int addr_width(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/circ_buffer_ram.sv
// circ_buffer_ram: simple dual-port memory with a registered, resettable read port
module circ_buffer_ram #(
  parameter int DW = 32,
  parameter int DEPTH = 16,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end
  always_ff @(posedge clk) begin
    if (rst) rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/axis_burst_buffer.sv
// axis_burst_buffer: AXIS slave buffer that releases words to a FIFO read port in bursts
module axis_burst_buffer
  import axis_pipe_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH = 16,
  parameter int THRESHOLD = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DATA_WIDTH-1:0]       s_axis_tdata,
  input  logic                        s_axis_tvalid,
  input  logic                        s_axis_tlast,
  output logic                        s_axis_tready,
  input  logic                        rd_en,
  output logic [DATA_WIDTH-1:0]       dout,
  output logic                        dout_valid,
  output logic                        data_ready,
  output logic                        empty,
  output logic                        full,
  output logic [addr_width(DEPTH):0]  count
);
  localparam int AW = addr_width(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] THR = CW'(THRESHOLD);
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] burst_left, count_next;
  logic flush_pending, wr_acc, rd_acc;
  burst_state_t state;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign s_axis_tready = !full;
  assign wr_acc = s_axis_tvalid && s_axis_tready;
  assign rd_acc = rd_en && data_ready && !empty;
  assign count_next = count + CW'(wr_acc) - CW'(rd_acc);
  circ_buffer_ram #(.DW(DATA_WIDTH), .DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk(clk),
    .rst(rst),
    .we(wr_acc),
    .waddr(wr_ptr),
    .wdata(s_axis_tdata),
    .re(rd_acc),
    .raddr(rd_ptr),
    .rdata(dout)
  );
  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      burst_left <= '0;
      flush_pending <= 1'b0;
      state <= COLLECT;
      data_ready <= 1'b0;
      dout_valid <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
      count <= count_next;
      dout_valid <= rd_acc;
      flush_pending <= (wr_acc && s_axis_tlast) || (flush_pending && count_next != '0);
      if (state == COLLECT) begin
        if (count >= THR || (flush_pending && !empty)) begin
          state <= RELEASE;
          data_ready <= 1'b1;
          burst_left <= count < THR ? count : THR;
        end
      end else if (rd_acc) begin
        burst_left <= burst_left - CW'(1);
        if (burst_left == CW'(1)) begin
          state <= COLLECT;
          data_ready <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_axis_burst_buffer.sv
// tb_axis_burst_buffer: table vectors, directed corner cases and a random scoreboard run
module tb_axis_burst_buffer;
  localparam int DW = 32;
  localparam int DEPTH = 16;
  localparam int THR = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [DW-1:0] s_axis_tdata = '0;
  logic s_axis_tvalid = 1'b0;
  logic s_axis_tlast = 1'b0;
  logic s_axis_tready;
  logic rd_en = 1'b0;
  logic [DW-1:0] dout;
  logic dout_valid, data_ready, empty, full;
  logic [4:0] count;
  always #5 clk = ~clk;
  axis_burst_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .THRESHOLD(THR)) dut (
    .clk(clk),
    .rst(rst),
    .s_axis_tdata(s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast),
    .s_axis_tready(s_axis_tready),
    .rd_en(rd_en),
    .dout(dout),
    .dout_valid(dout_valid),
    .data_ready(data_ready),
    .empty(empty),
    .full(full),
    .count(count)
  );
  typedef struct packed {logic [DW-1:0] d; logic l;} beat_t;
  typedef struct {
    logic rst, v, l, rd;
    logic [DW-1:0] d;
    logic dr, dv;
    logic [DW-1:0] dout;
    logic [4:0] cnt;
  } vec_t;
  int passed = 0, total = 0;
  beat_t src[$];
  logic [DW-1:0] mq[$];
  logic [DW-1:0] got[$];
  int occ = 0, reads = 0, target = 0;
  bit flush = 1'b0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask
  // Reference model: occupancy, flush and burst rules from interface events only
  task automatic tick();
    bit rb, w, r, drb, fb, wl;
    int ob;
    logic [DW-1:0] wd, e;
    rb = rst; drb = data_ready; fb = flush; ob = occ;
    wd = s_axis_tdata; wl = s_axis_tlast;
    w = !rb && s_axis_tvalid && s_axis_tready;
    r = !rb && rd_en && data_ready && !empty;
    @(posedge clk);
    #1;
    if (rb) begin
      mq.delete(); occ = 0; flush = 1'b0; reads = 0; target = 0;
      chk("rst_data_ready", 32'(data_ready), 0);
      chk("rst_count", 32'(count), 0);
      chk("rst_empty", 32'(empty), 1);
      chk("rst_full", 32'(full), 0);
      chk("rst_tready", 32'(s_axis_tready), 1);
      chk("rst_dout_valid", 32'(dout_valid), 0);
      chk("rst_dout", dout, 0);
      return;
    end
    if (w) mq.push_back(wd);
    occ = ob + int'(w) - int'(r);
    flush = (w && wl) || (fb && occ != 0);
    if (r) reads++;
    if (!drb) chk("dr_collect", 32'(data_ready), 32'(ob >= THR || (fb && ob > 0)));
    else chk("dr_release", 32'(data_ready), 32'(reads != target));
    if (data_ready && !drb) begin
      target = ob < THR ? ob : THR;
      reads = 0;
    end
    chk("count", 32'(count), 32'(occ));
    chk("empty", 32'(empty), 32'(occ == 0));
    chk("full", 32'(full), 32'(occ == DEPTH));
    chk("tready", 32'(s_axis_tready), 32'(occ != DEPTH));
    chk("dout_valid", 32'(dout_valid), 32'(r));
    if (r) begin
      chk("sb_nonempty", 32'(mq.size() > 0), 1);
      if (mq.size() > 0) begin
        e = mq.pop_front();
        chk("dout", dout, e);
        got.push_back(dout);
      end
    end
  endtask
  task automatic cyc(input bit rd);
    bit acc;
    rd_en = rd;
    s_axis_tvalid = src.size() > 0;
    s_axis_tdata = s_axis_tvalid ? src[0].d : '0;
    s_axis_tlast = s_axis_tvalid ? src[0].l : 1'b0;
    acc = s_axis_tvalid && s_axis_tready;
    tick();
    if (acc) void'(src.pop_front());
  endtask
  task automatic do_reset();
    rst = 1'b1;
    src.delete();
    cyc(1'b0);
    rst = 1'b0;
    got.delete();
  endtask
  task automatic run_until(input int n, input int bound, input bit rd);
    for (int i = 0; i < bound && got.size() < n; i++) cyc(rd);
    chk("drain_words", 32'(got.size()), 32'(n));
  endtask
  task automatic push_seq(input logic [DW-1:0] base, input int n, input bit last_on_end);
    for (int i = 0; i < n; i++) src.push_back('{d: base + DW'(i), l: last_on_end && i == n - 1});
  endtask
  vec_t tv[11];
  int n;
  initial begin
    tv[0]  = '{1, 0, 0, 0, 32'h0,  0, 0, 32'h0,  5'd0};
    tv[1]  = '{0, 1, 0, 1, 32'hDD, 0, 0, 32'h0,  5'd1};
    tv[2]  = '{0, 1, 0, 1, 32'hDE, 0, 0, 32'h0,  5'd2};
    tv[3]  = '{0, 1, 0, 1, 32'hDF, 0, 0, 32'h0,  5'd3};
    tv[4]  = '{0, 1, 0, 1, 32'hE0, 0, 0, 32'h0,  5'd4};
    tv[5]  = '{0, 0, 0, 1, 32'h0,  1, 0, 32'h0,  5'd4};
    tv[6]  = '{0, 0, 0, 1, 32'h0,  1, 1, 32'hDD, 5'd3};
    tv[7]  = '{0, 0, 0, 1, 32'h0,  1, 1, 32'hDE, 5'd2};
    tv[8]  = '{0, 0, 0, 1, 32'h0,  1, 1, 32'hDF, 5'd1};
    tv[9]  = '{0, 0, 0, 1, 32'h0,  0, 1, 32'hE0, 5'd0};
    tv[10] = '{0, 0, 0, 1, 32'h0,  0, 0, 32'hE0, 5'd0};
    for (int i = 0; i < 11; i++) begin
      rst = tv[i].rst; s_axis_tvalid = tv[i].v; s_axis_tlast = tv[i].l;
      rd_en = tv[i].rd; s_axis_tdata = tv[i].d;
      tick();
      chk($sformatf("t1_data_ready[%0d]", i), 32'(data_ready), 32'(tv[i].dr));
      chk($sformatf("t1_dout_valid[%0d]", i), 32'(dout_valid), 32'(tv[i].dv));
      chk($sformatf("t1_dout[%0d]", i), dout, tv[i].dout);
      chk($sformatf("t1_count[%0d]", i), 32'(count), 32'(tv[i].cnt));
    end
    do_reset();
    push_seq(32'h20, 3, 1'b0);
    for (int i = 0; i < 23; i++) cyc(1'b1);
    chk("t2_count", 32'(count), 3);
    chk("t2_no_output", 32'(got.size()), 0);
    chk("t2_data_ready", 32'(data_ready), 0);
    do_reset();
    push_seq(32'h10, 3, 1'b1);
    run_until(3, 50, 1'b1);
    for (int i = 0; i < 3 && i < got.size(); i++) chk($sformatf("t3_word[%0d]", i), got[i], 32'h10 + 32'(i));
    cyc(1'b1);
    chk("t3_count", 32'(count), 0);
    chk("t3_data_ready", 32'(data_ready), 0);
    chk("t3_flush_clear", 32'(dut.flush_pending), 0);
    do_reset();
    push_seq(32'h100, 20, 1'b0);
    for (int i = 0; i < 25; i++) cyc(1'b0);
    chk("t4_full", 32'(full), 1);
    chk("t4_count", 32'(count), 16);
    chk("t4_tready", 32'(s_axis_tready), 0);
    chk("t4_held_beats", 32'(src.size()), 4);
    run_until(20, 300, 1'b1);
    for (int i = 0; i < 20 && i < got.size(); i++) chk($sformatf("t4_word[%0d]", i), got[i], 32'h100 + 32'(i));
    do_reset();
    push_seq(32'h300, 48, 1'b1);
    for (int i = 0; i < 8; i++) cyc(1'b0);
    chk("t5_prefill", 32'(count), 8);
    run_until(48, 400, 1'b1);
    for (int i = 0; i < 48 && i < got.size(); i++) chk($sformatf("t5_word[%0d]", i), got[i], 32'h300 + 32'(i));
    do_reset();
    push_seq(32'h600, 6, 1'b0);
    for (int i = 0; i < 8; i++) cyc(1'b0);
    chk("t6_pre_data_ready", 32'(data_ready), 1);
    chk("t6_pre_count", 32'(count), 6);
    rst = 1'b1;
    cyc(1'b1);
    rst = 1'b0;
    chk("t6_data_ready", 32'(data_ready), 0);
    chk("t6_count", 32'(count), 0);
    chk("t6_empty", 32'(empty), 1);
    chk("t6_dout_valid", 32'(dout_valid), 0);
    chk("t6_tready", 32'(s_axis_tready), 1);
    got.delete();
    push_seq(32'hA0, 4, 1'b0);
    run_until(4, 50, 1'b1);
    for (int i = 0; i < 4 && i < got.size(); i++) chk($sformatf("t6_word[%0d]", i), got[i], 32'hA0 + 32'(i));
    do_reset();
    n = 0;
    for (int i = 0; i < 800; i++) begin
      if (src.size() < 2 && $urandom_range(2) != 0) begin
        src.push_back('{d: $urandom, l: $urandom_range(7) == 0});
        n++;
      end
      cyc(i < 400 ? $urandom_range(3) == 0 : $urandom_range(3) != 0);
    end
    src.push_back('{d: 32'h5A5A0000, l: 1'b1});
    n++;
    run_until(n, 600, 1'b1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
